// File: rtl/tictactoe_referee_if.sv
// Move channel between a move source (player input / AI engine) and the referee.
// Latency: none, wires only.
// Backpressure: a move transfers on a clock edge where mv_valid and mv_ready are both high.
interface tictactoe_referee_if;
  logic       mv_valid;
  logic       mv_ready;
  logic [1:0] mv_xoro;
  logic [1:0] mv_row;
  logic [1:0] mv_col;

  modport master (
    output mv_valid,
    output mv_xoro,
    output mv_row,
    output mv_col,
    input  mv_ready
  );

  modport slave (
    input  mv_valid,
    input  mv_xoro,
    input  mv_row,
    input  mv_col,
    output mv_ready
  );
endinterface

// File: rtl/tictactoe_referee.sv
// Tic-tac-toe referee: owns the 3x3 board, checks each move's legality and turn order, detects win/draw.
// Latency: legal move ready again 9 cycles after acceptance (1 check + 8 serial line scans); illegal move 1 cycle.
// Backpressure: mv_ready is high only while idle, so one move is in flight at a time.
module tictactoe_referee #(
  parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
  input  logic                ph1,
  input  logic                reset_b,
  input  logic                new_game,
  tictactoe_referee_if.slave  mv,
  output logic                err,
  output logic [2:0]          err_code,
  output logic [1:0]          win,
  output logic                game_over,
  output logic [1:0]          turn,
  output logic [3:0]          move_count,
  output logic [17:0]         board
);

  typedef enum logic [1:0] {READY, CHECK, SCAN} state_t;

  typedef struct packed {
    logic [1:0] xoro;
    logic [1:0] row;
    logic [1:0] col;
  } move_t;

  state_t     state, state_nxt;
  move_t      mv_q;
  logic [2:0] line_idx;
  logic       hit;

  logic       accept, place, reject, scan_step, scan_done;
  logic [2:0] chk_code;
  logic [3:0] cell_idx;
  logic [3:0] la, lb, lc;
  logic       line_hit;

  // Read one 2-bit cell; out-of-range indices read as empty.
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    logic [1:0] v;
    v = 2'b00;
    for (int i = 0; i < 9; i++) begin
      if (idx == i[3:0]) v = b[2*i +: 2];
    end
    return v;
  endfunction

  assign game_over   = (win != 2'b00);
  assign mv.mv_ready = (state == READY);

  // Linear cell index of the latched move; only meaningful when row/col are in range.
  always_comb begin
    cell_idx = ({2'b00, mv_q.row} * 4'd3) + {2'b00, mv_q.col};
  end

  // Rejection reason for the latched move, highest priority first; 0 means legal.
  always_comb begin
    chk_code = 3'd0;
    if (game_over)
      chk_code = 3'd5;
    else if (mv_q.xoro == 2'b00 || mv_q.xoro == 2'b11)
      chk_code = 3'd1;
    else if (mv_q.row == 2'd3 || mv_q.col == 2'd3)
      chk_code = 3'd2;
    else if (mv_q.xoro != turn)
      chk_code = 3'd3;
    else if (cell_at(board, cell_idx) != 2'b00)
      chk_code = 3'd4;
  end

  // Cells of the line under test: rows, then columns, then the two diagonals.
  always_comb begin
    la = 4'd0; lb = 4'd1; lc = 4'd2;
    case (line_idx)
      3'd0: begin la = 4'd0; lb = 4'd1; lc = 4'd2; end
      3'd1: begin la = 4'd3; lb = 4'd4; lc = 4'd5; end
      3'd2: begin la = 4'd6; lb = 4'd7; lc = 4'd8; end
      3'd3: begin la = 4'd0; lb = 4'd3; lc = 4'd6; end
      3'd4: begin la = 4'd1; lb = 4'd4; lc = 4'd7; end
      3'd5: begin la = 4'd2; lb = 4'd5; lc = 4'd8; end
      3'd6: begin la = 4'd0; lb = 4'd4; lc = 4'd8; end
      default: begin la = 4'd2; lb = 4'd4; lc = 4'd6; end
    endcase
    line_hit = (cell_at(board, la) == mv_q.xoro) &&
               (cell_at(board, lb) == mv_q.xoro) &&
               (cell_at(board, lc) == mv_q.xoro);
  end

  // State register.
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b)
      state <= READY;
    else
      state <= state_nxt;
  end

  // Next-state and datapath strobes; new_game overrides everything, including a waiting move.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    place     = 1'b0;
    reject    = 1'b0;
    scan_step = 1'b0;
    scan_done = 1'b0;
    if (new_game) begin
      state_nxt = READY;
    end else begin
      case (state)
        READY: begin
          if (mv.mv_valid) begin
            accept    = 1'b1;
            state_nxt = CHECK;
          end
        end
        CHECK: begin
          if (chk_code != 3'd0) begin
            reject    = 1'b1;
            state_nxt = READY;
          end else begin
            place     = 1'b1;
            state_nxt = SCAN;
          end
        end
        SCAN: begin
          scan_step = 1'b1;
          if (line_idx == 3'd7) begin
            scan_done = 1'b1;
            state_nxt = READY;
          end
        end
        default: state_nxt = READY;
      endcase
    end
  end

  // Board, score and error bookkeeping.
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      board      <= 18'd0;
      turn       <= FIRST_PLAYER;
      win        <= 2'b00;
      err        <= 1'b0;
      err_code   <= 3'd0;
      move_count <= 4'd0;
      mv_q       <= '0;
      line_idx   <= 3'd0;
      hit        <= 1'b0;
    end else if (new_game) begin
      board      <= 18'd0;
      turn       <= FIRST_PLAYER;
      win        <= 2'b00;
      err        <= 1'b0;
      err_code   <= 3'd0;
      move_count <= 4'd0;
      mv_q       <= '0;
      line_idx   <= 3'd0;
      hit        <= 1'b0;
    end else begin
      if (accept)
        mv_q <= '{xoro: mv.mv_xoro, row: mv.mv_row, col: mv.mv_col};
      if (reject) begin
        err      <= 1'b1;
        err_code <= chk_code;
      end
      if (place) begin
        for (int i = 0; i < 9; i++) begin
          if (cell_idx == i[3:0]) board[2*i +: 2] <= mv_q.xoro;
        end
        move_count <= move_count + 4'd1;
        err        <= 1'b0;
        err_code   <= 3'd0;
        line_idx   <= 3'd0;
        hit        <= 1'b0;
      end
      if (scan_step) begin
        hit <= hit | line_hit;
        // Hold at the last line rather than wrapping back to 0.
        if (!scan_done) line_idx <= line_idx + 3'd1;
      end
      if (scan_done) begin
        if (hit | line_hit)
          win <= mv_q.xoro;
        else if (move_count == 4'd9)
          win <= 2'b11;
        else
          turn <= {turn[0], turn[1]};
      end
    end
  end

endmodule

// File: tb/tb_tictactoe_referee.sv
// Directed bench for tictactoe_referee: vector table of moves plus new_game / reset abort sequences.
// Latency: measures cycles from acceptance to mv_ready returning for every move.
// Backpressure: each move waits for mv_ready before being presented.
module tb_tictactoe_referee;

  localparam logic [1:0] FP = 2'b01;

  logic        ph1;
  logic        reset_b;
  logic        new_game;
  logic        err;
  logic [2:0]  err_code;
  logic [1:0]  win;
  logic        game_over;
  logic [1:0]  turn;
  logic [3:0]  move_count;
  logic [17:0] board;

  tictactoe_referee_if mif ();

  tictactoe_referee #(.FIRST_PLAYER(FP)) dut (
    .ph1        (ph1),
    .reset_b    (reset_b),
    .new_game   (new_game),
    .mv         (mif.slave),
    .err        (err),
    .err_code   (err_code),
    .win        (win),
    .game_over  (game_over),
    .turn       (turn),
    .move_count (move_count),
    .board      (board)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  typedef struct {
    logic       ng;
    logic [1:0] xoro;
    logic [1:0] row;
    logic [1:0] col;
    logic       e_err;
    logic [2:0] e_code;
    logic [1:0] e_win;
    logic [1:0] e_turn;
    logic [3:0] e_cnt;
    int         e_lat;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic ng, input logic [1:0] x, input logic [1:0] r,
                              input logic [1:0] c, input logic e, input logic [2:0] code,
                              input logic [1:0] w, input logic [1:0] t, input logic [3:0] cnt,
                              input int lat);
    vec_t v;
    v.ng = ng; v.xoro = x; v.row = r; v.col = c;
    v.e_err = e; v.e_code = code; v.e_win = w; v.e_turn = t; v.e_cnt = cnt; v.e_lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_ng();
    new_game = 1'b1;
    @(posedge ph1); #1;
    new_game = 1'b0;
  endtask

  // Present one move when ready; lat = edges after acceptance until mv_ready returns.
  task automatic play(input logic [1:0] x, input logic [1:0] r, input logic [1:0] c, output int lat);
    int n;
    n = 0;
    while (!mif.mv_ready && n < 20) begin
      @(posedge ph1); #1;
      n++;
    end
    mif.mv_valid = 1'b1;
    mif.mv_xoro  = x;
    mif.mv_row   = r;
    mif.mv_col   = c;
    @(posedge ph1); #1;
    mif.mv_valid = 1'b0;
    lat = 0;
    while (!mif.mv_ready && lat < 20) begin
      @(posedge ph1); #1;
      lat++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_board"}, 32'(board), 32'd0);
    chk({tag, "_win"}, 32'(win), 32'd0);
    chk({tag, "_game_over"}, 32'(game_over), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
    chk({tag, "_move_count"}, 32'(move_count), 32'd0);
    chk({tag, "_turn"}, 32'(turn), 32'(FP));
    chk({tag, "_mv_ready"}, 32'(mif.mv_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] exp_board;
    int          lat;
    int          idx;
    vec_t        v;

    // Game 1: X wins on the top row; a later move is rejected as game over.
    vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b10, 1, 9));
    vecs.push_back(mk(0, 2'b10, 1, 1, 0, 0, 2'b00, 2'b01, 2, 9));
    vecs.push_back(mk(0, 2'b01, 0, 1, 0, 0, 2'b00, 2'b10, 3, 9));
    vecs.push_back(mk(0, 2'b10, 2, 2, 0, 0, 2'b00, 2'b01, 4, 9));
    vecs.push_back(mk(0, 2'b01, 0, 2, 0, 0, 2'b01, 2'b01, 5, 9));
    vecs.push_back(mk(0, 2'b10, 2, 0, 1, 5, 2'b01, 2'b01, 5, 1));
    // Game 2: wrong turn, occupied cell, bad symbol over range, range, then err clears.
    vecs.push_back(mk(1, 2'b10, 0, 0, 1, 3, 2'b00, 2'b01, 0, 1));
    vecs.push_back(mk(0, 2'b01, 1, 1, 0, 0, 2'b00, 2'b10, 1, 9));
    vecs.push_back(mk(0, 2'b10, 1, 1, 1, 4, 2'b00, 2'b10, 1, 1));
    vecs.push_back(mk(0, 2'b11, 3, 0, 1, 1, 2'b00, 2'b10, 1, 1));
    vecs.push_back(mk(0, 2'b01, 0, 3, 1, 2, 2'b00, 2'b10, 1, 1));
    vecs.push_back(mk(0, 2'b10, 0, 0, 0, 0, 2'b00, 2'b01, 2, 9));
    // Game 3: nine-move draw, then game-over rejections.
    vecs.push_back(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b10, 1, 9));
    vecs.push_back(mk(0, 2'b10, 0, 1, 0, 0, 2'b00, 2'b01, 2, 9));
    vecs.push_back(mk(0, 2'b01, 0, 2, 0, 0, 2'b00, 2'b10, 3, 9));
    vecs.push_back(mk(0, 2'b10, 1, 1, 0, 0, 2'b00, 2'b01, 4, 9));
    vecs.push_back(mk(0, 2'b01, 1, 0, 0, 0, 2'b00, 2'b10, 5, 9));
    vecs.push_back(mk(0, 2'b10, 1, 2, 0, 0, 2'b00, 2'b01, 6, 9));
    vecs.push_back(mk(0, 2'b01, 2, 1, 0, 0, 2'b00, 2'b10, 7, 9));
    vecs.push_back(mk(0, 2'b10, 2, 0, 0, 0, 2'b00, 2'b01, 8, 9));
    vecs.push_back(mk(0, 2'b01, 2, 2, 0, 0, 2'b11, 2'b01, 9, 9));
    vecs.push_back(mk(0, 2'b01, 0, 0, 1, 5, 2'b11, 2'b01, 9, 1));
    vecs.push_back(mk(0, 2'b00, 3, 3, 1, 5, 2'b11, 2'b01, 9, 1));

    reset_b      = 1'b0;
    new_game     = 1'b0;
    mif.mv_valid = 1'b0;
    mif.mv_xoro  = 2'b00;
    mif.mv_row   = 2'd0;
    mif.mv_col   = 2'd0;
    repeat (2) @(posedge ph1);
    #1 reset_b = 1'b1;
    chk_reset_vals("reset");

    exp_board = 18'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.ng) begin
        pulse_ng();
        exp_board = 18'd0;
      end
      play(v.xoro, v.row, v.col, lat);
      if (!v.e_err) begin
        idx = 2 * (3 * int'(v.row) + int'(v.col));
        exp_board[idx +: 2] = v.xoro;
      end
      chk($sformatf("v%0d_err", i), 32'(err), 32'(v.e_err));
      chk($sformatf("v%0d_err_code", i), 32'(err_code), 32'(v.e_code));
      chk($sformatf("v%0d_win", i), 32'(win), 32'(v.e_win));
      chk($sformatf("v%0d_game_over", i), 32'(game_over), 32'(v.e_win != 2'b00));
      chk($sformatf("v%0d_turn", i), 32'(turn), 32'(v.e_turn));
      chk($sformatf("v%0d_move_count", i), 32'(move_count), 32'(v.e_cnt));
      chk($sformatf("v%0d_board", i), 32'(board), 32'(exp_board));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v.e_lat));
    end

    // new_game arriving with a move during the scan aborts it and takes no move.
    pulse_ng();
    mif.mv_valid = 1'b1;
    mif.mv_xoro  = 2'b01;
    mif.mv_row   = 2'd0;
    mif.mv_col   = 2'd0;
    @(posedge ph1); #1;           // E0
    mif.mv_valid = 1'b0;
    repeat (3) begin
      @(posedge ph1); #1;         // E1..E3
    end
    chk("ng_scan_board_before", 32'(board), 32'h1);
    chk("ng_scan_ready_before", 32'(mif.mv_ready), 32'd0);
    new_game     = 1'b1;
    mif.mv_valid = 1'b1;
    mif.mv_row   = 2'd2;
    mif.mv_col   = 2'd2;
    @(posedge ph1); #1;           // E4
    new_game     = 1'b0;
    mif.mv_valid = 1'b0;
    chk_reset_vals("ng_scan");
    @(posedge ph1); #1;
    chk("ng_scan_board_after", 32'(board), 32'd0);
    chk("ng_scan_count_after", 32'(move_count), 32'd0);
    chk("ng_scan_ready_after", 32'(mif.mv_ready), 32'd1);

    // Asynchronous reset in the middle of a scan clears without a clock edge.
    mif.mv_valid = 1'b1;
    mif.mv_xoro  = 2'b01;
    mif.mv_row   = 2'd1;
    mif.mv_col   = 2'd1;
    @(posedge ph1); #1;           // E0
    mif.mv_valid = 1'b0;
    repeat (2) begin
      @(posedge ph1); #1;         // E1, E2
    end
    #2;
    chk("rst_scan_board_before", 32'(board), 32'h100);
    chk("rst_scan_count_before", 32'(move_count), 32'd1);
    reset_b = 1'b0;
    #1;
    chk_reset_vals("rst_scan");
    @(posedge ph1); #1;
    reset_b = 1'b1;
    @(posedge ph1); #1;
    chk_reset_vals("rst_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tictactoe_referee.md
Name: tictactoe_referee

Overview:
- Move-checking end of the game interface: consumes (xoro, row, col) moves, keeps the authoritative 3x3 board and enforces legality and turn order.
- Detects a win or a draw and reports the result.
- Sits between the move source (player input path or AI engine) and the display/score logic.
- Checks the board with a serial 8-line win scan, one line per cycle.

Parameters:
- FIRST_PLAYER, 2'b01, symbol that moves first after reset/new_game (2'b01 = X, 2'b10 = O).

Ports:
- ph1 input 1: single clock; all state changes on the rising edge.
- reset_b input 1: asynchronous, active-low reset.
- new_game input 1: synchronous clear of the game, sampled on ph1.
- mv_valid input 1: a move is presented.
- mv_ready output 1: the referee can accept a move.
- mv_xoro input 2: symbol (01 = X, 10 = O; 00 and 11 are illegal).
- mv_row input 2: row 0..2 (3 is illegal).
- mv_col input 2: column 0..2 (3 is illegal).
- err output 1: the last accepted move was rejected.
- err_code output 3: reason for the rejection.
- win output 2: 00 none, 01 X won, 10 O won, 11 draw.
- game_over output 1: win != 00.
- turn output 2: symbol expected next.
- move_count output 4: number of legal moves placed (0..9).
- board output 18: cell (r,c) at bits [2*(3r+c)+1 : 2*(3r+c)], 00 = empty.

Behaviour:
- Reset (reset_b = 0, async): board = 0, turn = FIRST_PLAYER, win = 00, game_over = 0, err = 0, err_code = 0, move_count = 0, state READY, mv_ready = 1.
- States: READY, CHECK, SCAN. mv_ready = 1 only in READY.
- Accept condition: mv_valid & mv_ready & ~new_game at a ph1 edge (E0). The move is latched and the state goes to CHECK.
- CHECK (resolved at E1), errors in priority order:
  - 5: game_over = 1
  - 1: bad symbol (mv_xoro = 00 or 11)
  - 2: row or col = 3
  - 3: symbol != turn
  - 4: cell occupied
- CHECK, illegal move: err = 1, err_code set, board/turn/move_count unchanged, state goes to READY. mv_ready is high again in the cycle after E1.
- CHECK, legal move: write the cell, move_count += 1, err = 0, err_code = 0, line_idx = 0, state goes to SCAN.
- err and err_code hold until the next accepted move's CHECK or new_game.
- SCAN (E2..E9): each edge tests line_idx against the just-placed symbol, ORs the result into a hit flag, then line_idx += 1.
  - Line order: 0-2 rows 0-2; 3-5 columns 0-2; 6 = (0,0)(1,1)(2,2); 7 = (0,2)(1,1)(2,0).
  - No early exit; all 8 lines are always scanned.
- At E9 (line_idx = 7):
  - if hit, win = mover symbol;
  - else if move_count = 9, win = 11;
  - else turn toggles (01 <-> 10).
  - State goes to READY.
  - Turn does not toggle on a win or a draw.
- Legal-move latency: accept at E0, ready again after E9 (9 cycles). Illegal-move latency: 1 cycle.
- game_over is combinational from win. Once the game is over, moves are still accepted and rejected with code 5.
- new_game (synchronous, any state, aborts a CHECK or SCAN in progress) has the same effect as reset at the next edge. A simultaneous mv_valid is not accepted.
- line_idx is 3 bits and is never allowed to wrap within a scan. move_count saturates at 9 by construction (the 10th legal move is impossible).

Test Plan:
- Reset, then X (0,0), O (1,1), X (0,1), O (2,2), X (0,2), each issued when mv_ready = 1 -> after the last move's E9: win = 01, game_over = 1, move_count = 5, turn = 01, board[5:0] = 010101.
- With turn = X, present O at (0,0) -> one cycle later: err = 1, err_code = 3, board = 0, mv_ready = 1.
- Place X (1,1), then O (1,1) -> err_code = 4; move_count stays 1; turn stays 10.
- Present xoro = 11, row = 3 -> err_code = 1 (symbol beats range). Then xoro = 01, col = 3 -> err_code = 2.
- Nine-move draw sequence X(0,0) O(0,1) X(0,2) O(1,1) X(1,0) O(1,2) X(2,1) O(2,0) X(2,2) -> win = 11, move_count = 9. A further move -> err_code = 5.
- new_game asserted during SCAN (E4) with mv_valid = 1 -> next edge: board = 0, win = 00, turn = FIRST_PLAYER, no move accepted. Also drop reset_b mid-SCAN -> all outputs reach reset values immediately.
